// File: rtl/mc_lsu_pkg.sv
// Shared types and helpers for the multi-cycle core load/store unit.
package mc_lsu_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, ISSUE2, RESP} state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    // Lane mask across two adjacent words; bits above the word width spill into word+1.
    function automatic logic [15:0] be_gen(input logic [1:0] size, input logic [2:0] offset);
        logic [15:0] m;
        case (size)
            SZ_B:    m = 16'h0001;
            SZ_H:    m = 16'h0003;
            SZ_W:    m = 16'h000F;
            default: m = 16'h00FF;
        endcase
        return m << offset;
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] offset);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return offset[0];
            SZ_W:    return |offset[1:0];
            default: return |offset;
        endcase
    endfunction

endpackage

// File: rtl/mc_lsu_if.sv
// CU request/response and word-wide memory bus seen by the load/store unit.
interface mc_lsu_if #(parameter int XLEN = 32, parameter int ADDR_W = 8);
    localparam int LANES = XLEN / 8;
    localparam int WA_W  = ADDR_W - $clog2(LANES);

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_se;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic              rsp_valid;
    logic [XLEN-1:0]   rsp_rdata;
    logic              rsp_err;
    logic              mem_req;
    logic              mem_we;
    logic [WA_W-1:0]   mem_addr;
    logic [LANES-1:0]  mem_be;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN-1:0]   mem_rdata;
    logic              mem_ack;

    modport slave (
        input  req_valid, req_we, req_size, req_se, req_addr, req_wdata, mem_rdata, mem_ack,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_size, req_se, req_addr, req_wdata, mem_rdata, mem_ack,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
endinterface

// File: rtl/mc_lsu_align.sv
// Load data alignment: shifts the (possibly two-word) lane window down, trims to size, extends.
module mc_lsu_align
    import mc_lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2*XLEN-1:0] data,
    input  logic [2:0]        offset,
    input  logic [1:0]        size,
    input  logic              se,
    output logic [XLEN-1:0]   result
);
    logic [XLEN-1:0] low;
    logic [XLEN-1:0] keep;
    logic            sgn;

    always_comb begin
        low = XLEN'(data >> {offset, 3'b000});
        case (size)
            SZ_B:    begin keep = XLEN'(8'hFF);         sgn = low[7];  end
            SZ_H:    begin keep = XLEN'(16'hFFFF);      sgn = low[15]; end
            SZ_W:    begin keep = XLEN'(32'hFFFF_FFFF); sgn = low[31]; end
            default: begin keep = '1;                   sgn = 1'b0;    end
        endcase
        result = (low & keep) | ((se && sgn) ? ~keep : '0);
    end
endmodule

// File: rtl/mc_load_store_unit.sv
// Load/store unit: one CU request per handshake, word bus with byte enables, wait states and timeout.
// Define MISALIGN_SPLIT_EN to split word-crossing accesses into two bus transfers instead of erroring.
module mc_load_store_unit
    import mc_lsu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 16
) (
    input logic     clk,
    input logic     rst_,
    mc_lsu_if.slave bus
);
    localparam int LANES = XLEN / 8;
    localparam int OFF_W = $clog2(LANES);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t             state, nxt;
    logic               we_r, se_r;
    logic [1:0]         size_r;
    logic [2:0]         off_r;
    logic [LANES-1:0]   be_hi_r;
    logic [XLEN-1:0]    wd_hi_r, rd_lo, ext;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         off_in;
    logic [2*LANES-1:0] be_in;
    logic [2*XLEN-1:0]  wd_in, algn_in;
    logic               bad, tmo;

    always_comb begin
        off_in = 3'(bus.req_addr[OFF_W-1:0]);
        be_in  = (2*LANES)'(be_gen(bus.req_size, off_in));
        wd_in  = {{XLEN{1'b0}}, bus.req_wdata} << {off_in, 3'b000};
        for (int i = 0; i < 2*LANES; i++)
            if (!be_in[i]) wd_in[8*i +: 8] = 8'h00;
`ifdef MISALIGN_SPLIT_EN
        bad = (XLEN == 32) && (bus.req_size == SZ_D);
`else
        bad = ((XLEN == 32) && (bus.req_size == SZ_D)) || misaligned(bus.req_size, off_in);
`endif
        tmo = (cnt == CNT_W'(TIMEOUT - 1)) && !bus.mem_ack;
        algn_in = (state == ISSUE2) ? {bus.mem_rdata, rd_lo} : {{XLEN{1'b0}}, bus.mem_rdata};
    end

    always_ff @(posedge clk) begin
        if (rst_) state <= IDLE;
        else      state <= nxt;
    end

    always_comb begin
        nxt           = state;
        bus.req_ready = 1'b0;
        bus.mem_req   = 1'b0;
        bus.rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) nxt = bad ? RESP : ISSUE;
            end
            ISSUE: begin
                bus.mem_req = 1'b1;
                if (bus.mem_ack) begin
`ifdef MISALIGN_SPLIT_EN
                    nxt = (|be_hi_r) ? ISSUE2 : RESP;
`else
                    nxt = RESP;
`endif
                end else if (tmo) nxt = RESP;
            end
            ISSUE2: begin
                bus.mem_req = 1'b1;
                if (bus.mem_ack || tmo) nxt = RESP;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                nxt           = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    assign bus.mem_we = we_r & bus.mem_req;

    mc_lsu_align #(.XLEN(XLEN)) u_align (
        .data   (algn_in),
        .offset (off_r),
        .size   (size_r),
        .se     (se_r),
        .result (ext)
    );

    always_ff @(posedge clk) begin
        if (rst_) begin
            we_r <= 1'b0; se_r <= 1'b0; size_r <= '0; off_r <= '0;
            be_hi_r <= '0; wd_hi_r <= '0; rd_lo <= '0; cnt <= '0;
            bus.mem_addr <= '0; bus.mem_be <= '0; bus.mem_wdata <= '0;
            bus.rsp_rdata <= '0; bus.rsp_err <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    we_r          <= bus.req_we;
                    se_r          <= bus.req_se;
                    size_r        <= bus.req_size;
                    off_r         <= off_in;
                    cnt           <= '0;
                    bus.mem_addr  <= bus.req_addr[ADDR_W-1:OFF_W];
                    bus.mem_be    <= be_in[LANES-1:0];
                    be_hi_r       <= be_in[2*LANES-1:LANES];
                    bus.mem_wdata <= wd_in[XLEN-1:0];
                    wd_hi_r       <= wd_in[2*XLEN-1:XLEN];
                    if (bad) begin
                        bus.rsp_rdata <= '0;
                        bus.rsp_err   <= 1'b1;
                    end
                end
                ISSUE, ISSUE2: begin
                    if (bus.mem_ack) begin
                        cnt   <= '0;
                        rd_lo <= bus.mem_rdata;
                        // Second phase reuses the bus registers; word address wraps naturally.
                        if (nxt == ISSUE2) begin
                            bus.mem_addr  <= bus.mem_addr + 1'b1;
                            bus.mem_be    <= be_hi_r;
                            bus.mem_wdata <= wd_hi_r;
                        end else begin
                            bus.rsp_rdata <= we_r ? '0 : ext;
                            bus.rsp_err   <= 1'b0;
                        end
                    end else if (tmo) begin
                        bus.rsp_rdata <= '0;
                        bus.rsp_err   <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mc_load_store_unit.sv
// Directed bench for mc_load_store_unit with a response scoreboard and a wait-state memory model.
module tb_mc_load_store_unit;
    import mc_lsu_pkg::*;

    localparam int XLEN = 32, ADDR_W = 8, TIMEOUT = 16;

    typedef struct {
        logic [XLEN-1:0] rdata;
        logic            err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_ = 1'b1;
    always #5 clk = ~clk;

    mc_lsu_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus ();

    mc_load_store_unit #(.XLEN(XLEN), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus)
    );

    exp_t            sb[$];
    int              checks = 0, passed = 0, rsp_seen = 0;
    logic [XLEN-1:0] mem [64];
    int              ack_wait = 0;
    bit              ack_en = 1'b1, late_ack = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Memory model: acks after ack_wait idle cycles of mem_req, writes enabled lanes.
    initial begin
        int wcnt;
        wcnt = 0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            bus.mem_ack = late_ack;
            if (bus.mem_req && ack_en && !rst_) begin
                if (wcnt >= ack_wait) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = mem[bus.mem_addr];
                    if (bus.mem_we)
                        for (int i = 0; i < XLEN/8; i++)
                            if (bus.mem_be[i]) mem[bus.mem_addr][8*i +: 8] = bus.mem_wdata[8*i +: 8];
                    wcnt = 0;
                end else wcnt++;
            end else wcnt = 0;
        end
    end

    // Response monitor: pops the scoreboard on each rsp_valid pulse.
    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            if (!rst_ && bus.rsp_valid) begin
                rsp_seen++;
                if (sb.size() == 0) chk("rsp_unexpected", bus.rsp_valid, 1'b0);
                else begin
                    e = sb.pop_front();
                    chk("rsp_rdata", bus.rsp_rdata, e.rdata);
                    chk("rsp_err", bus.rsp_err, e.err);
                end
            end
        end
    end

    task automatic send(input logic we, input logic [1:0] size, input logic se, input logic [7:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err);
        exp_t e;
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = size;
        bus.req_se = se; bus.req_addr = addr; bus.req_wdata = wdata;
        e.rdata = exp_rd; e.err = exp_err;
        sb.push_back(e);
        @(negedge clk);
        chk("req_ready_at_accept", bus.req_ready, 1'b1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    // Called on a negedge; n counts further negedges until rsp_valid.
    task automatic wait_rsp(input int max, output int n);
        n = 0;
        while (!bus.rsp_valid && n < max) begin
            @(negedge clk);
            n++;
        end
        if (!bus.rsp_valid) chk("rsp_arrival_timeout", bus.rsp_valid, 1'b1);
    endtask

    initial begin
        int n, k, s0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = '0;
        bus.req_se = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        mem[4] = 32'hDEAD_BEEF;
        mem[8] = 32'h4433_2211;
        mem[9] = 32'h8877_6655;

        repeat (3) @(posedge clk);
        #1 rst_ = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", bus.req_ready, 1'b1);
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_rsp_err", bus.rsp_err, 1'b0);
        chk("rst_rsp_rdata", bus.rsp_rdata, '0);
        chk("rst_mem_req", bus.mem_req, 1'b0);
        chk("rst_mem_we", bus.mem_we, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, '0);
        chk("rst_mem_be", bus.mem_be, '0);
        chk("rst_mem_wdata", bus.mem_wdata, '0);

        // Load word, two wait states
        ack_wait = 2;
        send(1'b0, SZ_W, 1'b0, 8'h10, '0, 32'hDEAD_BEEF, 1'b0);
        @(negedge clk);
        chk("lw_mem_req", bus.mem_req, 1'b1);
        chk("lw_req_ready_busy", bus.req_ready, 1'b0);
        chk("lw_mem_be", bus.mem_be, 4'hF);
        chk("lw_mem_addr", bus.mem_addr, 6'h04);
        wait_rsp(20, n);
        chk("lw_latency", n, 3);

        // Load byte from top lane, sign then zero extend
        ack_wait = 0;
        mem[4] = 32'h8012_3456;
        send(1'b0, SZ_B, 1'b1, 8'h13, '0, 32'hFFFF_FF80, 1'b0);
        @(negedge clk);
        chk("lb_mem_be", bus.mem_be, 4'h8);
        wait_rsp(20, n);
        send(1'b0, SZ_B, 1'b0, 8'h13, '0, 32'h0000_0080, 1'b0);
        @(negedge clk);
        wait_rsp(20, n);

        // Store half to upper lanes, upper wdata bits must be trimmed
        send(1'b1, SZ_H, 1'b0, 8'h06, 32'h1234_BEEF, 32'h0, 1'b0);
        @(negedge clk);
        chk("sh_mem_we", bus.mem_we, 1'b1);
        chk("sh_mem_be", bus.mem_be, 4'hC);
        chk("sh_mem_wdata", bus.mem_wdata, 32'hBEEF_0000);
        chk("sh_mem_addr", bus.mem_addr, 6'h01);
        wait_rsp(20, n);
        chk("sh_mem_written", mem[1], 32'hBEEF_0000);

        // Misaligned word load
`ifdef MISALIGN_SPLIT_EN
        ack_wait = 1;
        send(1'b0, SZ_W, 1'b0, 8'h21, '0, 32'h5544_3322, 1'b0);
        @(negedge clk);
        chk("mis_ph1_be", bus.mem_be, 4'hE);
        chk("mis_ph1_addr", bus.mem_addr, 6'h08);
        k = 0;
        while (bus.mem_addr != 6'h09 && k < 10) begin @(negedge clk); k++; end
        chk("mis_ph2_addr", bus.mem_addr, 6'h09);
        chk("mis_ph2_be", bus.mem_be, 4'h1);
        chk("mis_ph2_req", bus.mem_req, 1'b1);
        wait_rsp(20, n);
        ack_wait = 0;
`else
        send(1'b0, SZ_W, 1'b0, 8'h21, '0, 32'h0, 1'b1);
        @(negedge clk);
        chk("mis_no_bus", bus.mem_req, 1'b0);
        wait_rsp(20, n);
        chk("mis_latency", n, 0);
`endif

        // Timeout with no ack, then a stray late ack
        ack_en = 1'b0;
        send(1'b0, SZ_W, 1'b0, 8'h10, '0, 32'h0, 1'b1);
        @(negedge clk);
        k = 0;
        while (bus.mem_req && k < 40) begin k++; @(negedge clk); end
        chk("tmo_req_cycles", k, TIMEOUT);
        chk("tmo_rsp_valid", bus.rsp_valid, 1'b1);
        late_ack = 1'b1;
        @(negedge clk);
        late_ack = 1'b0;
        s0 = rsp_seen;
        @(negedge clk);
        chk("late_ack_ready", bus.req_ready, 1'b1);
        chk("late_ack_mem_req", bus.mem_req, 1'b0);
        repeat (2) @(negedge clk);
        chk("late_ack_no_rsp", rsp_seen, s0);

        // Reset during ISSUE
        send(1'b0, SZ_W, 1'b0, 8'h10, '0, 32'h0, 1'b0);
        @(negedge clk);
        chk("rst_mid_req_before", bus.mem_req, 1'b1);
        @(posedge clk); #1;
        rst_ = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        rst_ = 1'b0;
        ack_en = 1'b1;
        s0 = rsp_seen;
        @(negedge clk);
        chk("rst_mid_mem_req", bus.mem_req, 1'b0);
        chk("rst_mid_ready", bus.req_ready, 1'b1);
        repeat (4) @(negedge clk);
        chk("rst_mid_no_rsp", rsp_seen, s0);

        // Illegal dword size on a 32-bit build
        send(1'b0, SZ_D, 1'b0, 8'h00, '0, 32'h0, 1'b1);
        @(negedge clk);
        chk("ill_no_bus", bus.mem_req, 1'b0);
        wait_rsp(20, n);
        chk("ill_latency", n, 0);

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
